router_pkt_tx: RTL and testbench
================================

Name: router_pkt_tx

Overview:
- Packet source that drives the router input port: pkt_data, pkt_valid, router_busy and router_error.
- Accepts a request (destination, length), buffers the payload from a host load handshake, then sends the frame: header byte, payload bytes, parity byte.
- Paces every byte on router_busy and reports the router's error indication per packet.
- Used as the stimulus/traffic front end for the 1x3 router.

Parameters:
- ERR_WAIT, 3: cycles after the parity byte is consumed during which router_error is monitored.
- MAX_LEN, 63: maximum payload length. Buffer depth is MAX_LEN; the length field is 6 bits.

Ports:
- clock  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- start  in  1  request strobe, sampled only in IDLE
- dest  in  2  destination port; 0..2 valid, 3 invalid
- len  in  6  payload byte count; 1..63 valid
- load_valid  in  1  host payload byte valid
- load_data  in  8  host payload byte
- load_ready  out  1  block accepts payload byte
- router_busy  in  1  router stall; a byte is consumed on an edge where router_busy=0
- router_error  in  1  router parity-mismatch indication
- pkt_data  out  8  byte to router data input
- pkt_valid  out  1  high for header and payload, low for parity
- tx_active  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at packet completion
- parity_err  out  1  sticky, router reported error for the last packet
- req_reject  out  1  one-cycle pulse, illegal request

Behaviour:
- Reset (synchronous, at the edge with reset=1):
  - state=IDLE.
  - pkt_data=0, pkt_valid=0, load_ready=0, tx_active=0, done=0, req_reject=0, parity_err=0.
  - Counters and parity cleared.
  - Reset mid-packet abandons the frame; pkt_valid is 0 from the next edge.
- All outputs are registered.
- IDLE:
  - On start=1 with dest==3 or len==0: req_reject=1 for one cycle, remain IDLE.
  - On a legal start:
    - latch dest and len.
    - hdr={len,dest}; parity:=hdr.
    - parity_err:=0, cnt:=0.
    - -> LOAD.
- LOAD:
  - load_ready=1.
  - Each edge with load_valid&load_ready: buf[cnt]:=load_data, parity^=load_data, cnt++.
  - Gaps in load_valid are allowed.
  - On the write of byte len-1: load_ready:=0, pkt_data:=hdr, pkt_valid:=1, -> HEADER.
  - The header is therefore on the port in the first cycle after the last load.
- HEADER:
  - Hold pkt_data/pkt_valid while router_busy=1.
  - On an edge with router_busy=0: pkt_data:=buf[0], idx:=0, -> PAYLOAD.
- PAYLOAD:
  - pkt_valid=1. Hold while router_busy=1.
  - On an edge with router_busy=0: if idx==len-1, pkt_data:=parity, pkt_valid:=0, -> PARITY; else idx++, pkt_data:=buf[idx+1].
  - pkt_valid never drops between header and last payload byte (router has no bubble support).
- PARITY:
  - pkt_valid=0. Hold parity byte while router_busy=1.
  - On an edge with router_busy=0: cnt:=0, -> ERRCHK.
- ERRCHK:
  - pkt_data:=0.
  - Each cycle: if router_error=1, parity_err:=1.
  - After ERR_WAIT cycles: done=1 for one cycle, -> IDLE.
- start outside IDLE is ignored (no reject, no latch).
- Parity is the 8-bit XOR of the header and all payload bytes.
- Arithmetic: cnt/idx are 6 bits and never wrap, since len ≤ 63.
- Simultaneous events:
  - reset has priority over everything.
  - router_busy and router_error are sampled independently.
  - load_valid in any state other than LOAD is ignored.
- Back-to-back: a new start is accepted the cycle after done, when state is IDLE again.

Test Plan:
- dest=1, len=3, payload 11,22,33, router_busy=0 -> pkt_data 0x0D,0x11,0x22,0x33 with pkt_valid=1, then 0x0D with pkt_valid=0. ERR_WAIT=3 cycles later done=1 and parity_err=0.
- Same packet, router_busy=1 for 2 cycles while 0x22 is presented -> 0x22 held 3 cycles, pkt_valid stays 1, parity still 0x0D.
- start with dest=3, len=5 -> req_reject pulse, tx_active=0, pkt_valid=0. Repeat with dest=0, len=0 -> same response.
- Legal packet with router_error=1 on the 2nd cycle of ERRCHK -> parity_err=1 after done. Next legal start clears it to 0.
- dest=2, len=63, load_valid toggling every other cycle -> 63 writes accepted, header 0xFE, 63 payload bytes in order, parity equals the XOR of all bytes.
- reset=1 while idx=1 in PAYLOAD -> next cycle pkt_valid=0, tx_active=0, state IDLE. A following legal packet is sent correctly.

Source files
------------

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: traffic source for the 1x3 router input port.
// Takes a (dest, len) request and buffers len payload bytes from the host.
// It then sends header {len,dest}, the payload and an XOR parity byte, paced
// by router_busy. After the frame it watches router_error for ERR_WAIT cycles.
module router_pkt_tx #(
  parameter int ERR_WAIT = 3,
  parameter int MAX_LEN  = 63
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] dest,
  input  logic [5:0] len,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  output logic       load_ready,
  input  logic       router_busy,
  input  logic       router_error,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  output logic       tx_active,
  output logic       done,
  output logic       parity_err,
  output logic       req_reject
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HEADER,
    PAYLOAD,
    PARITY,
    ERRCHK
  } state_e;

  localparam logic [5:0] ERR_LAST = 6'(ERR_WAIT - 1);

  state_e     state_q;
  logic [1:0] dest_q;
  logic [5:0] len_q;
  logic [7:0] parity_q;
  logic [5:0] cnt_q;
  logic [5:0] idx_q;
  logic [7:0] buf_q [MAX_LEN];

  logic [7:0] pkt_data_q;
  logic       pkt_valid_q;
  logic       load_ready_q;
  logic       tx_active_q;
  logic       done_q;
  logic       parity_err_q;
  logic       req_reject_q;

  logic       load_fire;
  logic [7:0] hdr;
  logic [7:0] parity_d;
  logic [5:0] cnt_d;
  logic [5:0] idx_d;
  logic [5:0] len_last;

  // Handshake decode and next-value helpers shared by the buffer and the FSM.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    load_fire = 1'b0;
    if (state_q == LOAD && load_valid && load_ready_q) load_fire = 1'b1;
    hdr      = {len_q, dest_q};
    parity_d = parity_q ^ load_data;
    cnt_d    = cnt_q + 6'd1;
    idx_d    = idx_q + 6'd1;
    len_last = len_q - 6'd1;
  end

  // Payload buffer write port; contents are only read after being written.
  always_ff @(posedge clock) begin
    // NOTE: the buffer is pure data storage, so it is deliberately left out of reset.
    if (load_fire) buf_q[cnt_q] <= load_data;
  end

  // Control FSM with all port-facing outputs registered.
  always_ff @(posedge clock) begin
    // NOTE: sequential state is written with <= so every register samples pre-edge values.
    if (reset) begin
      state_q      <= IDLE;
      dest_q       <= 2'd0;
      len_q        <= 6'd0;
      parity_q     <= 8'd0;
      cnt_q        <= 6'd0;
      idx_q        <= 6'd0;
      pkt_data_q   <= 8'd0;
      pkt_valid_q  <= 1'b0;
      load_ready_q <= 1'b0;
      tx_active_q  <= 1'b0;
      done_q       <= 1'b0;
      parity_err_q <= 1'b0;
      req_reject_q <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      req_reject_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (dest == 2'd3 || len == 6'd0) begin
              req_reject_q <= 1'b1;
            end else begin
              dest_q       <= dest;
              len_q        <= len;
              parity_q     <= {len, dest};
              parity_err_q <= 1'b0;
              cnt_q        <= 6'd0;
              load_ready_q <= 1'b1;
              tx_active_q  <= 1'b1;
              state_q      <= LOAD;
            end
          end
        end
        LOAD: begin
          if (load_fire) begin
            parity_q <= parity_d;
            cnt_q    <= cnt_d;
            if (cnt_q == len_last) begin
              load_ready_q <= 1'b0;
              pkt_data_q   <= hdr;
              pkt_valid_q  <= 1'b1;
              state_q      <= HEADER;
            end
          end
        end
        HEADER: begin
          if (!router_busy) begin
            pkt_data_q <= buf_q[0];
            idx_q      <= 6'd0;
            state_q    <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (!router_busy) begin
            if (idx_q == len_last) begin
              pkt_data_q  <= parity_q;
              pkt_valid_q <= 1'b0;
              state_q     <= PARITY;
            end else begin
              idx_q      <= idx_d;
              pkt_data_q <= buf_q[idx_d];
            end
          end
        end
        PARITY: begin
          if (!router_busy) begin
            cnt_q      <= 6'd0;
            pkt_data_q <= 8'd0;
            state_q    <= ERRCHK;
          end
        end
        ERRCHK: begin
          if (router_error) parity_err_q <= 1'b1;
          if (cnt_q == ERR_LAST) begin
            done_q      <= 1'b1;
            tx_active_q <= 1'b0;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pkt_data   = pkt_data_q;
  assign pkt_valid  = pkt_valid_q;
  assign load_ready = load_ready_q;
  assign tx_active  = tx_active_q;
  assign done       = done_q;
  assign parity_err = parity_err_q;
  assign req_reject = req_reject_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: frame contents, stalls, rejects,
// router error reporting, maximum length with load gaps, and mid-frame reset.
`timescale 1ns/1ps
module tb_router_pkt_tx;

  logic       clock;
  logic       reset;
  logic       start;
  logic [1:0] dest;
  logic [5:0] len;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       router_busy;
  logic       router_error;
  logic [7:0] pkt_data;
  logic       pkt_valid;
  logic       tx_active;
  logic       done;
  logic       parity_err;
  logic       req_reject;

  int         n_cmp;
  int         n_fail;
  logic [7:0] pay [64];
  logic [7:0] par_model;

  router_pkt_tx #(.ERR_WAIT(3), .MAX_LEN(63)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .dest        (dest),
    .len         (len),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .router_busy (router_busy),
    .router_error(router_error),
    .pkt_data    (pkt_data),
    .pkt_valid   (pkt_valid),
    .tx_active   (tx_active),
    .done        (done),
    .parity_err  (parity_err),
    .req_reject  (req_reject)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Advance one edge and settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full request/load/transmit/error-window sequence for one frame using pay[].
  task automatic send_frame(input logic [1:0] d, input logic [5:0] l, input bit gap,
                            input int busy_idx, input int busy_cycles, input int err_cycle,
                            input logic [7:0] exp_hdr, input logic [7:0] exp_par,
                            input bit exp_perr);
    start = 1'b1; dest = d; len = l;
    tick();
    start = 1'b0; dest = 2'd0; len = 6'd0;
    check("start_tx_active", tx_active, 8'd1);
    check("start_load_ready", load_ready, 8'd1);
    check("start_perr_clear", parity_err, 8'd0);
    check("start_no_valid", pkt_valid, 8'd0);
    for (int i = 0; i < int'(l); i++) begin
      load_valid = 1'b1; load_data = pay[i];
      tick();
      load_valid = 1'b0;
      if (gap && i != int'(l) - 1) begin
        // Illegal start while busy must be ignored, not rejected.
        start = 1'b1; dest = 2'd3;
        tick();
        start = 1'b0; dest = 2'd0;
        check("gap_no_reject", req_reject, 8'd0);
        check("gap_load_ready", load_ready, 8'd1);
      end
    end
    check("hdr_data", pkt_data, exp_hdr);
    check("hdr_valid", pkt_valid, 8'd1);
    check("hdr_load_ready", load_ready, 8'd0);
    for (int i = 0; i < int'(l); i++) begin
      tick();
      check("pay_data", pkt_data, pay[i]);
      check("pay_valid", pkt_valid, 8'd1);
      if (i == busy_idx) begin
        router_busy = 1'b1;
        for (int k = 0; k < busy_cycles; k++) begin
          tick();
          check("stall_data", pkt_data, pay[i]);
          check("stall_valid", pkt_valid, 8'd1);
        end
        router_busy = 1'b0;
      end
    end
    tick();
    check("par_data", pkt_data, exp_par);
    check("par_valid", pkt_valid, 8'd0);
    tick();
    check("errchk_data", pkt_data, 8'd0);
    check("errchk_no_done", done, 8'd0);
    check("errchk_active", tx_active, 8'd1);
    for (int c = 1; c <= 3; c++) begin
      router_error = (c == err_cycle);
      tick();
      router_error = 1'b0;
      if (c < 3) check("errchk_wait_done", done, 8'd0);
    end
    check("done_pulse", done, 8'd1);
    check("done_tx_idle", tx_active, 8'd0);
    check("done_perr", parity_err, {7'd0, exp_perr});
    tick();
    check("done_one_cycle", done, 8'd0);
    check("perr_sticky", parity_err, {7'd0, exp_perr});
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b1; start = 1'b0; dest = 2'd0; len = 6'd0;
    load_valid = 1'b0; load_data = 8'd0; router_busy = 1'b0; router_error = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_pkt_data", pkt_data, 8'd0);
    check("rst_pkt_valid", pkt_valid, 8'd0);
    check("rst_load_ready", load_ready, 8'd0);
    check("rst_tx_active", tx_active, 8'd0);
    check("rst_done", done, 8'd0);
    check("rst_parity_err", parity_err, 8'd0);
    check("rst_req_reject", req_reject, 8'd0);

    // Basic frame: hdr {3,1}=0x0D, parity 0x0D^0x11^0x22^0x33 = 0x0D.
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    send_frame(2'd1, 6'd3, 1'b0, -1, 0, 0, 8'h0D, 8'h0D, 1'b0);

    // Same frame with a two-cycle stall on 0x22.
    send_frame(2'd1, 6'd3, 1'b0, 1, 2, 0, 8'h0D, 8'h0D, 1'b0);

    // Illegal requests: dest=3, then len=0.
    start = 1'b1; dest = 2'd3; len = 6'd5;
    tick();
    start = 1'b0;
    check("rej_dest_pulse", req_reject, 8'd1);
    check("rej_dest_tx", tx_active, 8'd0);
    check("rej_dest_valid", pkt_valid, 8'd0);
    tick();
    check("rej_dest_one_cycle", req_reject, 8'd0);
    check("rej_dest_stay_idle", load_ready, 8'd0);
    start = 1'b1; dest = 2'd0; len = 6'd0;
    tick();
    start = 1'b0;
    check("rej_len_pulse", req_reject, 8'd1);
    check("rej_len_tx", tx_active, 8'd0);
    check("rej_len_valid", pkt_valid, 8'd0);
    tick();
    check("rej_len_one_cycle", req_reject, 8'd0);

    // Router error in ERRCHK cycle 2: hdr {2,0}=0x08, parity 0x08^0x5A^0xA5 = 0xF7.
    pay[0] = 8'h5A; pay[1] = 8'hA5;
    send_frame(2'd0, 6'd2, 1'b0, -1, 0, 2, 8'h08, 8'hF7, 1'b1);

    // Max length with load gaps: hdr {63,2}=0xFE; next start clears parity_err.
    par_model = 8'hFE;
    for (int i = 0; i < 63; i++) begin
      pay[i] = 8'(i * 7 + 5);
      par_model = par_model ^ pay[i];
    end
    send_frame(2'd2, 6'd63, 1'b1, -1, 0, 0, 8'hFE, par_model, 1'b0);

    // Reset while idx=1 in PAYLOAD.
    pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC;
    start = 1'b1; dest = 2'd0; len = 6'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_data = pay[i];
      tick();
    end
    load_valid = 1'b0;
    check("rstmid_hdr", pkt_data, 8'h0C);
    tick(); tick();
    check("rstmid_idx1", pkt_data, 8'hBB);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_valid", pkt_valid, 8'd0);
    check("rstmid_tx", tx_active, 8'd0);
    check("rstmid_data", pkt_data, 8'd0);
    check("rstmid_done", done, 8'd0);

    // Frame after reset: hdr {1,1}=0x05, parity 0x05^0x3C = 0x39.
    pay[0] = 8'h3C;
    send_frame(2'd1, 6'd1, 1'b0, -1, 0, 0, 8'h05, 8'h39, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
